// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounces the keypad scanner code, turns each fresh press into one
// key event, accumulates decimal digits and hands committed values out over valid/ready.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS      = 4,
  parameter int VALUE_W         = 14
) (
  input  logic                            sys_clk_in,
  input  logic                            reset,
  input  logic [3:0]                      key_num,
  output logic [VALUE_W-1:0]              value_out,
  output logic                            value_valid,
  input  logic                            value_ready,
  output logic [4*MAX_DIGITS-1:0]         digits_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count,
  output logic                            key_event,
  output logic                            overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DC_W  = $clog2(MAX_DIGITS + 1);

  localparam logic [CNT_W-1:0]        STABLE_CNT     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DC_W-1:0]         FULL_CNT       = DC_W'(MAX_DIGITS);
  localparam logic [4*MAX_DIGITS-1:0] BLANK          = {MAX_DIGITS{4'hF}};
  localparam logic [3:0]              KEY_LAST_DIGIT = 4'd9;
  localparam logic [3:0]              KEY_CLEAR      = 4'd10;
  localparam logic [3:0]              KEY_ENTER      = 4'd11;
  localparam logic [3:0]              KEY_NONE       = 4'd15;

  typedef enum logic {
    ENTRY  = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              key_q;
  logic [CNT_W-1:0]        stab_cnt;
  logic                    held;
  logic                    stable;
  logic                    fire;
  logic [VALUE_W-1:0]      value;
  logic [VALUE_W-1:0]      value_nxt;
  logic [VALUE_W-1:0]      vout_nxt;
  logic                    valid_nxt;
  logic [4*MAX_DIGITS-1:0] bcd_nxt;
  logic [DC_W-1:0]         count_nxt;
  logic                    ovf_nxt;

  // Shift-and-add decimal accumulate: v*10 + d without a multiplier.
  function automatic logic [VALUE_W-1:0] times_ten_plus(input logic [VALUE_W-1:0] v,
                                                        input logic [3:0] d);
    return (v << 3'd3) + (v << 3'd1) + VALUE_W'(d);
  endfunction

  assign stable = (stab_cnt == STABLE_CNT);
  assign fire   = stable && (key_q != KEY_NONE) && !held;

  // Debounce counter, press/release tracking and the registered event pulse.
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      key_q     <= KEY_NONE;
      stab_cnt  <= '0;
      held      <= 1'b0;
      key_event <= 1'b0;
    end else begin
      key_q <= key_num;
      if (key_num != key_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STABLE_CNT) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
      // A held key must be seen stably released before it can fire again.
      if (fire) begin
        held <= 1'b1;
      end else if (stable && (key_q == KEY_NONE)) begin
        held <= 1'b0;
      end
      key_event <= fire;
    end
  end

  // Entry FSM next state and buffer updates for the event fired this cycle.
  always_comb begin
    state_nxt = state;
    value_nxt = value;
    bcd_nxt   = digits_bcd;
    count_nxt = digit_count;
    ovf_nxt   = overflow;
    vout_nxt  = value_out;
    valid_nxt = value_valid;
    case (state)
      ENTRY: begin
        if (fire) begin
          if (key_q <= KEY_LAST_DIGIT) begin
            if (digit_count < FULL_CNT) begin
              value_nxt = times_ten_plus(value, key_q);
              bcd_nxt   = {digits_bcd[4*MAX_DIGITS-5:0], key_q};
              count_nxt = digit_count + DC_W'(1);
            end else begin
              ovf_nxt = 1'b1;
            end
          end else if (key_q == KEY_CLEAR) begin
            value_nxt = '0;
            bcd_nxt   = BLANK;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
          end else if (key_q == KEY_ENTER) begin
            if (digit_count != '0) begin
              vout_nxt  = value;
              valid_nxt = 1'b1;
              state_nxt = COMMIT;
              value_nxt = '0;
              bcd_nxt   = BLANK;
              count_nxt = '0;
              ovf_nxt   = 1'b0;
            end else begin
              state_nxt = ENTRY;
            end
          end else begin
            // Codes 12-14 only produce the event pulse.
            state_nxt = ENTRY;
          end
        end else begin
          state_nxt = ENTRY;
        end
      end
      COMMIT: begin
        // Events here are dropped; only the handshake moves the FSM.
        if (value_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ENTRY;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ENTRY;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and entry buffer registers.
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      state       <= ENTRY;
      value       <= '0;
      digits_bcd  <= BLANK;
      digit_count <= '0;
      overflow    <= 1'b0;
      value_out   <= '0;
      value_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      value       <= value_nxt;
      digits_bcd  <= bcd_nxt;
      digit_count <= count_nxt;
      overflow    <= ovf_nxt;
      value_out   <= vout_nxt;
      value_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: directed scenarios plus random presses checked against a
// digit-queue reference model of the entry rules.
module tb_keypad_entry_ctrl;

  localparam int D    = 16;
  localparam int MAXD = 4;
  localparam int VW   = 14;
  localparam int E    = D + 2;  // event tick after a new code is driven

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    key_num;
  logic [VW-1:0] value_out;
  logic          value_valid;
  logic          value_ready;
  logic [15:0]   digits_bcd;
  logic [2:0]    digit_count;
  logic          key_event;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  int            ev_cnt;
  int            ev_first;
  int            tick_no;
  int            vcnt;
  logic [VW-1:0] vval;

  int digs[$];
  bit m_ovf;
  bit m_pend;
  int m_pend_val;
  int m_last_out;
  int exp_vcnt;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .MAX_DIGITS     (MAXD),
    .VALUE_W        (VW)
  ) dut (
    .sys_clk_in (clk),
    .reset      (reset),
    .key_num    (key_num),
    .value_out  (value_out),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .digits_bcd (digits_bcd),
    .digit_count(digit_count),
    .key_event  (key_event),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    ev_cnt   = 0;
    ev_first = 0;
    tick_no  = 0;
    vcnt     = 0;
    vval     = '0;
  endtask

  task automatic drive(input logic [3:0] code, input int n);
    key_num = code;
    for (int i = 0; i < n; i++) begin
      tick();
      tick_no++;
      if (key_event) begin
        ev_cnt++;
        if (ev_first == 0) ev_first = tick_no;
      end
      if (value_valid) begin
        vcnt++;
        vval = value_out;
      end
    end
  endtask

  function automatic int model_value();
    int v;
    v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function automatic logic [15:0] model_bcd();
    logic [15:0] b;
    int          t;
    b = 16'hFFFF;
    for (int i = 0; i < digs.size(); i++) begin
      t = digs[digs.size() - 1 - i];
      b[4*i +: 4] = t[3:0];
    end
    return b;
  endfunction

  task automatic model_reset();
    digs.delete();
    m_ovf      = 1'b0;
    m_pend     = 1'b0;
    m_pend_val = 0;
    m_last_out = 0;
  endtask

  // One accepted press lasting 'ticks' cycles, with ready held at 'rdy' throughout.
  task automatic model_press(input int code, input bit rdy, input int ticks);
    exp_vcnt = 0;
    if (m_pend && rdy) m_pend = 1'b0;
    if (m_pend) begin
      exp_vcnt = ticks;
    end else if (code <= 9) begin
      if (digs.size() < MAXD) digs.push_back(code);
      else m_ovf = 1'b1;
    end else if (code == 10) begin
      digs.delete();
      m_ovf = 1'b0;
    end else if (code == 11 && digs.size() > 0) begin
      m_pend_val = model_value();
      m_last_out = m_pend_val;
      digs.delete();
      m_ovf = 1'b0;
      if (rdy) exp_vcnt = 1;
      else begin
        m_pend   = 1'b1;
        exp_vcnt = ticks - E + 1;
      end
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel, input string tag);
    clr_counts();
    model_press(int'(code), value_ready, hold + rel);
    drive(code, hold);
    drive(4'hF, rel);
    chk({tag, "_events"}, ev_cnt, 1);
    chk({tag, "_ev_tick"}, ev_first, E);
    chk({tag, "_bcd"}, digits_bcd, model_bcd());
    chk({tag, "_count"}, digit_count, digs.size());
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_valid"}, value_valid, m_pend);
    chk({tag, "_vcnt"}, vcnt, exp_vcnt);
    chk({tag, "_vout"}, value_out, m_last_out);
    if (exp_vcnt > 0) chk({tag, "_vval"}, vval, m_pend_val);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vout"}, value_out, 0);
    chk({tag, "_valid"}, value_valid, 0);
    chk({tag, "_bcd"}, digits_bcd, 16'hFFFF);
    chk({tag, "_count"}, digit_count, 0);
    chk({tag, "_event"}, key_event, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int         r;
    logic [3:0] c;

    reset       = 1'b1;
    key_num     = 4'hF;
    value_ready = 1'b0;
    model_reset();
    tick();
    tick();
    chk_reset("reset");
    reset = 1'b0;

    // Digit sequence then ENTER with ready already high.
    value_ready = 1'b1;
    press(4'd1, 3*D, 3*D, "d1");
    press(4'd2, 3*D, 3*D, "d2");
    press(4'd3, 3*D, 3*D, "d3");
    press(4'd4, 3*D, 3*D, "d4");
    chk("seq_bcd", digits_bcd, 16'h1234);
    chk("seq_count", digit_count, 4);
    press(4'd11, 3*D, 3*D, "enter1234");
    chk("enter_val", vval, 1234);
    chk("enter_vcnt", vcnt, 1);
    chk("enter_bcd", digits_bcd, 16'hFFFF);

    // Overflow, clear, ENTER on empty buffer.
    press(4'd9, 3*D, 3*D, "o9a");
    press(4'd9, 3*D, 3*D, "o9b");
    press(4'd9, 3*D, 3*D, "o9c");
    press(4'd9, 3*D, 3*D, "o9d");
    press(4'd5, 3*D, 3*D, "o5");
    chk("ovf_set", overflow, 1);
    chk("ovf_bcd", digits_bcd, 16'h9999);
    press(4'd10, 3*D, 3*D, "oclr");
    chk("clr_ovf", overflow, 0);
    chk("clr_bcd", digits_bcd, 16'hFFFF);
    press(4'd11, 3*D, 3*D, "oenter");
    chk("empty_enter_vcnt", vcnt, 0);

    // Debounce: short glitch, long hold, direct code-to-code change.
    clr_counts();
    drive(4'd7, D);
    drive(4'hF, 3*D);
    chk("glitch_events", ev_cnt, 0);
    clr_counts();
    model_press(7, value_ready, 0);
    drive(4'd7, 10*D);
    chk("hold7_events", ev_cnt, 1);
    chk("hold7_tick", ev_first, E);
    clr_counts();
    drive(4'd8, 3*D);
    drive(4'hF, 3*D);
    chk("direct8_events", ev_cnt, 0);
    chk("direct8_bcd", digits_bcd, 16'hFFF7);
    chk("direct8_model_bcd", digits_bcd, model_bcd());
    press(4'd10, 3*D, 3*D, "dclr");

    // Backpressure: value held while ready is low, events dropped.
    value_ready = 1'b0;
    press(4'd4, 3*D, 3*D, "bp4");
    press(4'd2, 3*D, 3*D, "bp2");
    press(4'd11, 3*D, 3*D, "bpent");
    chk("bp_vout", value_out, 42);
    press(4'd5, 3*D, 3*D, "bp5");
    press(4'd10, 3*D, 3*D, "bpclr");
    chk("bp_valid_held", value_valid, 1);
    chk("bp_vout_held", value_out, 42);
    chk("bp_bcd_held", digits_bcd, 16'hFFFF);
    value_ready = 1'b1;
    tick();
    m_pend = 1'b0;
    chk("bp_drop", value_valid, 0);
    chk("bp_vout_after", value_out, 42);
    press(4'd5, 3*D, 3*D, "nx5");
    press(4'd11, 3*D, 3*D, "nxent");
    chk("nx_val", vval, 5);

    // Reset while a value is pending and a key is held.
    value_ready = 1'b0;
    press(4'd3, 3*D, 3*D, "rc3");
    press(4'd11, 3*D, 3*D, "rcent");
    clr_counts();
    model_press(6, value_ready, 3*D);
    drive(4'd6, 3*D);
    chk("rc_drop_events", ev_cnt, 1);
    chk("rc_valid_before", value_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("rc");
    model_reset();
    clr_counts();
    model_press(6, value_ready, 6*D);
    drive(4'd6, 3*D);
    drive(4'hF, 3*D);
    chk("rc_redetect_events", ev_cnt, 1);
    chk("rc_redetect_tick", ev_first, E);
    chk("rc_redetect_bcd", digits_bcd, 16'hFFF6);
    chk("rc_redetect_count", digit_count, 1);
    value_ready = 1'b1;
    press(4'd10, 3*D, 3*D, "rcclr");

    // Ignored codes still pulse key_event.
    press(4'd12, 3*D, 3*D, "ig12");
    press(4'd13, 3*D, 3*D, "ig13");
    press(4'd14, 3*D, 3*D, "ig14");
    chk("ig_bcd", digits_bcd, 16'hFFFF);

    // Random presses with random ready.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 15));
      if (r <= 9) c = 4'(r);
      else if (r == 12) c = 4'd10;
      else if (r == 13) c = 4'(12 + int'($urandom_range(0, 2)));
      else c = 4'd11;
      value_ready = 1'($urandom_range(0, 1));
      press(c, int'($urandom_range(D + 1, 2*D)), int'($urandom_range(D + 1, 2*D)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Entry controller that sits behind the 4x3 keypad scanner and turns its raw key code into committed multi-digit numbers. Debounces the scanner's `num` code, converts each fresh press into one key event, accumulates decimal digits into a binary value, and hands the committed value to a consumer over a valid/ready handshake. Also drives BCD digit outputs for the seven-segment display path.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, 16: consecutive `sys_clk_in` cycles a code must be unchanged before it counts as stable. Must be ≥1.
- `MAX_DIGITS`, 4: maximum digits per entry.
- `VALUE_W`, 14: width of the binary value. Must hold 10^MAX_DIGITS−1.

**Ports**
- `sys_clk_in`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `key_num`, input, 4: scanner key code.
  - 0–9 are digits, 10 is CLEAR, 11 is ENTER, 15 is no key.
  - 12–14 are ignored.
- `value_out`, output, VALUE_W: committed binary value. Stable while `value_valid` is high.
- `value_valid`, output, 1: committed value available.
- `value_ready`, input, 1: consumer accepts `value_out`.
- `digits_bcd`, output, 4*MAX_DIGITS: digits entered so far.
  - Most recent digit is in [3:0]; older digits sit in higher nibbles.
  - Unused nibbles are 4'hF (blank).
- `digit_count`, output, $clog2(MAX_DIGITS+1): number of digits entered.
- `key_event`, output, 1: one-cycle pulse per accepted press.
- `overflow`, output, 1: sticky. Set when a digit is pressed with the buffer full.

## Operation

**Debounce / event detector**
- `key_q` registers `key_num` every cycle.
- `stab_cnt` behaviour:
  - Cleared to 0 when `key_num != key_q`.
  - Otherwise increments, saturating at DEBOUNCE_CYCLES.
- Stable means `stab_cnt == DEBOUNCE_CYCLES`.
- `held` flag:
  - Set when an event fires.
  - Cleared when stable with `key_q == 15`.
- An event fires when all of these hold: stable, `key_q != 15`, `held == 0`.
  - `key_event` pulses for exactly one cycle.
  - The event carries code `key_q`.
- A held key gives exactly one event. A new event requires a stable release (15) first.
- Direct code-to-code transitions (A→B without 15 between) do not generate a second event.

**Entry FSM, states ENTRY and COMMIT**
- In ENTRY:
  - **Digit d**, count < MAX_DIGITS:
    - value ← value*10 + d. Compute ×10 as (v<<3)+(v<<1); no multiplier.
    - `digits_bcd` shifts left one nibble and inserts d at [3:0].
    - count increments.
  - **Digit d**, count == MAX_DIGITS: buffer unchanged, `overflow` ← 1.
  - **CLEAR**:
    - value ← 0, count ← 0, `digits_bcd` ← all F, `overflow` ← 0.
    - Works in any count state.
  - **ENTER**, count == 0: ignored.
  - **ENTER**, count > 0:
    - `value_out` ← value, `value_valid` ← 1, go to COMMIT.
    - Working buffer is cleared as for CLEAR.
  - **Codes 12–14**: `key_event` still pulses; no buffer change.
- In COMMIT:
  - `value_valid` stays high and `value_out` stays frozen until `value_ready` is sampled high.
  - On that edge: `value_valid` ← 0, go to ENTRY.
  - Key events in COMMIT are dropped: `key_event` still pulses, buffer and `overflow` are unchanged.
  - A CLEAR in COMMIT does not retract the committed value.

**Reset**
- `reset` high at a rising edge forces:
  - FSM = ENTRY.
  - `key_q` = 15, `stab_cnt` = 0, `held` = 0.
  - `value_out` = 0, `value_valid` = 0.
  - `digits_bcd` = all F, `digit_count` = 0.
  - `key_event` = 0, `overflow` = 0.
- Reset mid-COMMIT discards the pending value.

## Timing

- `key_event` and all buffer updates are registered outputs.
- Latency: if `key_num` changes to a new code that is applied at edge N and held, `stab_cnt` reaches DEBOUNCE_CYCLES at edge N+1+DEBOUNCE_CYCLES. `key_event`, `digits_bcd`, `digit_count` and `overflow` update at edge N+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES+1 cycles produces no event.
- On ENTER, `value_valid` rises on the same edge as `key_event`.
- `value_valid` falls on the first edge where `value_ready` = 1. `value_ready` may already be high when `value_valid` rises; the transfer then completes one edge later.
- Handshake rule: `value_valid` never deasserts without `value_ready`. `value_out` never changes while `value_valid` = 1.
- An event and a `value_ready` on the same edge in COMMIT: the handshake completes and the event is dropped.

## Test plan

- **Digit sequence.** Reset, then press 1,2,3,4 (each held 3×DEBOUNCE_CYCLES, released as long).
  - Required: 4 `key_event` pulses, `digits_bcd` = 16'h1234, `digit_count` = 4.
  - Then ENTER with `value_ready` = 1: `value_out` = 1234, `value_valid` high for exactly 1 cycle, buffer back to FFFF/0.
- **Overflow and clear.** Press 9,9,9,9,5.
  - Required: `overflow` = 1, `digits_bcd` = 16'h9999.
  - Then CLEAR: `overflow` = 0, `digits_bcd` = 16'hFFFF, `digit_count` = 0.
  - Then ENTER: no `value_valid`.
- **Debounce.** Pulse `key_num` = 7 for DEBOUNCE_CYCLES cycles, then 15.
  - Required: no event.
  - Then hold 7 for 10×DEBOUNCE_CYCLES: exactly one event, exactly at edge N+2+DEBOUNCE_CYCLES.
  - Then 7→8 directly with no release: no second event.
- **Backpressure.** Enter 42 and ENTER with `value_ready` = 0 for 50 cycles; press 5 and CLEAR during that window.
  - Required: `value_valid` stays 1, `value_out` stays 42, buffer unchanged.
  - Then raise `value_ready`: `value_valid` drops the next edge.
  - Then a new entry 5 + ENTER: `value_out` = 5.
- **Reset mid-COMMIT.** Assert `reset` for 1 cycle while `value_valid` = 1, during a held key.
  - Required: every output at its reset value on the next edge.
  - The still-held key produces one event after stable re-detection.
- **Ignored codes.** Press 12, 13, 14.
  - Required: 3 `key_event` pulses, `digits_bcd`, `digit_count` and `overflow` unchanged.
